// File: rtl/sm_warp_scheduler_pkg.sv
// Shared constants and helpers for the SM warp issue scheduler.
// Fallback warp-count defines for builds that do not pull in the common define file first.
`ifndef NUM_WARP
`define NUM_WARP 8
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif

package sm_warp_scheduler_pkg;

    localparam int unsigned NUM_WARP   = `NUM_WARP;
    localparam int unsigned DEPTH_WARP = `DEPTH_WARP;

    // Cooldown counter must hold ISSUE_GAP; a zero gap still needs one bit.
    function automatic int unsigned cd_width(input int unsigned gap);
        return (gap == 0) ? 1 : $clog2(gap + 1);
    endfunction

endpackage

// File: rtl/sm_warp_scheduler_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr, wrapping, via a double-width masked search.
module rr_arbiter #(
    parameter int unsigned N = 8,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt_oh
);

    logic [N-1:0]   masked;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] gnt_dbl;
    logic           found;

    always_comb begin
        masked = '0;
        for (int unsigned i = 0; i < N; i++) begin
            masked[i] = req[i] && (i >= 32'(ptr));
        end
        // Upper copy is the unmasked request, catching the wrap past N-1.
        dbl     = {req, masked};
        gnt_dbl = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < 2 * N; i++) begin
            if (!found && dbl[i]) begin
                gnt_dbl[i] = 1'b1;
                found      = 1'b1;
            end
        end
        gnt_oh = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];
    end

endmodule

// File: rtl/sm_warp_scheduler.sv
// Per-SM round-robin warp issue scheduler with per-warp post-issue cooldown.
`ifndef NUM_WARP
`define NUM_WARP 8
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif

module sm_warp_scheduler
    import sm_warp_scheduler_pkg::*;
#(
    parameter int unsigned ISSUE_GAP = 2,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [`NUM_WARP-1:0]   inst_buffer_has_data_i,
    input  logic [`NUM_WARP-1:0]   warp_active_i,
    input  logic [`NUM_WARP-1:0]   scoreboard_ready_i,
    input  logic                   issue_ready_i,
    output logic [`NUM_WARP-1:0]   warp_to_issue_oh_o,
    output logic                   issue_valid_o,
    output logic [`DEPTH_WARP-1:0] issue_wid_o,
    output logic                   sched_idle_o,
    output logic [CNT_WIDTH-1:0]   issue_count_o
);

    localparam int unsigned CD_W  = cd_width(ISSUE_GAP);
    localparam int unsigned PTR_W = DEPTH_WARP;

    logic [NUM_WARP-1:0] eligible;
    logic [NUM_WARP-1:0] arb_gnt;
    logic [NUM_WARP-1:0] grant;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    next_ptr;
    logic [CD_W-1:0]     cooldown [NUM_WARP];

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_WARP; i++) begin
            eligible[i] = inst_buffer_has_data_i[i] && warp_active_i[i] &&
                          scoreboard_ready_i[i] && (cooldown[i] == '0);
        end
    end

    rr_arbiter #(.N(NUM_WARP)) u_rr_arbiter (
        .req    (eligible),
        .ptr    (rr_ptr),
        .gnt_oh (arb_gnt)
    );

    assign grant              = (issue_ready_i && rst_n) ? arb_gnt : '0;
    assign warp_to_issue_oh_o = grant;
    assign sched_idle_o       = ~|eligible;

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_WARP; i++) begin
            if (grant[i]) grant_idx = grant_idx | PTR_W'(i);
        end
        next_ptr = (grant_idx == PTR_W'(NUM_WARP - 1)) ? '0 : grant_idx + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            issue_valid_o <= 1'b0;
            issue_wid_o   <= '0;
            issue_count_o <= '0;
            for (int unsigned i = 0; i < NUM_WARP; i++) cooldown[i] <= '0;
        end else begin
            issue_valid_o <= |grant;
            if (|grant) begin
                rr_ptr        <= next_ptr;
                issue_wid_o   <= grant_idx;
                issue_count_o <= issue_count_o + CNT_WIDTH'(1);
            end
            // Deactivation wins over everything; a grant implies active, so load never conflicts.
            for (int unsigned i = 0; i < NUM_WARP; i++) begin
                if (!warp_active_i[i])        cooldown[i] <= '0;
                else if (grant[i])            cooldown[i] <= CD_W'(ISSUE_GAP);
                else if (cooldown[i] != '0)   cooldown[i] <= cooldown[i] - CD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sm_warp_scheduler.sv
// Self-checking bench for sm_warp_scheduler: per-scenario tasks with a queue scoreboard for issued IDs.
`ifndef NUM_WARP
`define NUM_WARP 8
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif

module tb_sm_warp_scheduler;

    localparam int NW = `NUM_WARP;
    localparam int DW = `DEPTH_WARP;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NW-1:0] has_data = '0;
    logic [NW-1:0] active = '0;
    logic [NW-1:0] sb_ready = '0;
    logic          ready = 1'b0;

    logic [NW-1:0] oh, oh0;
    logic          valid, valid0, idle, idle0;
    logic [DW-1:0] wid, wid0;
    logic [31:0]   count;
    logic [3:0]    count0;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int exp_q0[$];
    int exp_count = 0;

    always #5 clk = ~clk;

    sm_warp_scheduler #(.ISSUE_GAP(2), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_buffer_has_data_i(has_data), .warp_active_i(active),
        .scoreboard_ready_i(sb_ready), .issue_ready_i(ready),
        .warp_to_issue_oh_o(oh), .issue_valid_o(valid), .issue_wid_o(wid),
        .sched_idle_o(idle), .issue_count_o(count)
    );

    sm_warp_scheduler #(.ISSUE_GAP(0), .CNT_WIDTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .inst_buffer_has_data_i(has_data), .warp_active_i(active),
        .scoreboard_ready_i(sb_ready), .issue_ready_i(ready),
        .warp_to_issue_oh_o(oh0), .issue_valid_o(valid0), .issue_wid_o(wid0),
        .sched_idle_o(idle0), .issue_count_o(count0)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        exp_q0.delete();
        exp_count = 0;
    endtask

    task automatic test_reset();
        int w;
        rst_n = 1'b0; has_data = '1; active = '1; sb_ready = '1; ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (oh !== '0) begin failures++; $display("FAIL reset_oh got=%h exp=00", oh); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (wid !== '0) begin failures++; $display("FAIL reset_wid got=%0d exp=0", wid); end
        rst_n = 1'b1;
        exp_q.delete(); exp_count = 0;
        #1;
        checks++; if (oh !== 8'h01) begin failures++; $display("FAIL reset_first_grant got=%h exp=01", oh); end
        exp_q.push_back(0); exp_count++;
        @(posedge clk); #1;
        w = exp_q.pop_front();
        checks++; if (valid !== 1'b1 || wid !== DW'(w)) begin failures++; $display("FAIL reset_first_wid got=%b/%0d exp=1/%0d", valid, wid, w); end
        checks++; if (count !== 32'(exp_count)) begin failures++; $display("FAIL reset_first_count got=%0d exp=%0d", count, exp_count); end
    endtask

    task automatic test_round_robin();
        logic [NW-1:0] e;
        int w;
        do_reset();
        has_data = '1; active = '1; sb_ready = '1; ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            e = NW'(1) << (k % NW);
            checks++; if (oh0 !== e) begin failures++; $display("FAIL rr_oh k=%0d got=%h exp=%h", k, oh0, e); end
            exp_q0.push_back(k % NW);
            @(posedge clk); #1;
            w = exp_q0.pop_front();
            checks++; if (valid0 !== 1'b1 || wid0 !== DW'(w)) begin failures++; $display("FAIL rr_wid k=%0d got=%b/%0d exp=1/%0d", k, valid0, wid0, w); end
        end
        // 20 grants on a 4-bit counter wrap to 4.
        checks++; if (count0 !== 4'd4) begin failures++; $display("FAIL rr_count_wrap got=%0d exp=4", count0); end
    endtask

    task automatic test_cooldown();
        logic [NW-1:0] e;
        int w;
        do_reset();
        has_data = 8'h08; active = '1; sb_ready = '1; ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            #1;
            e = (c % 3 == 0) ? 8'h08 : 8'h00;
            checks++; if (oh !== e) begin failures++; $display("FAIL cooldown_oh c=%0d got=%h exp=%h", c, oh, e); end
            checks++; if (idle !== (e == 0)) begin failures++; $display("FAIL cooldown_idle c=%0d got=%b exp=%b", c, idle, (e == 0)); end
            if (e != 0) begin exp_q.push_back(3); exp_count++; end
            @(posedge clk); #1;
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                checks++; if (valid !== 1'b1 || wid !== DW'(w)) begin failures++; $display("FAIL cooldown_wid c=%0d got=%b/%0d exp=1/%0d", c, valid, wid, w); end
            end else begin
                checks++; if (valid !== 1'b0) begin failures++; $display("FAIL cooldown_valid c=%0d got=%b exp=0", c, valid); end
            end
        end
        checks++; if (count !== 32'(exp_count)) begin failures++; $display("FAIL cooldown_count got=%0d exp=%0d", count, exp_count); end
    endtask

    task automatic test_backpressure();
        int w;
        do_reset();
        has_data = 8'h20; active = '1; sb_ready = '1; ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (oh !== '0) begin failures++; $display("FAIL bp_oh c=%0d got=%h exp=00", c, oh); end
            checks++; if (idle !== 1'b0) begin failures++; $display("FAIL bp_idle c=%0d got=%b exp=0", c, idle); end
            @(posedge clk); #1;
            checks++; if (valid !== 1'b0) begin failures++; $display("FAIL bp_valid c=%0d got=%b exp=0", c, valid); end
        end
        ready = 1'b1;
        #1;
        checks++; if (oh !== 8'h20) begin failures++; $display("FAIL bp_release_oh got=%h exp=20", oh); end
        exp_q.push_back(5);
        @(posedge clk); #1;
        w = exp_q.pop_front();
        checks++; if (valid !== 1'b1 || wid !== DW'(w)) begin failures++; $display("FAIL bp_release_wid got=%b/%0d exp=1/%0d", valid, wid, w); end
        // Pointer now past warp 5; warp 5 is cooling, so warp 6 wins.
        has_data = '1;
        #1;
        checks++; if (oh !== 8'h40) begin failures++; $display("FAIL bp_ptr_adv got=%h exp=40", oh); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap_sparse();
        logic [NW-1:0] seq [4];
        int w;
        seq[0] = 8'h40; seq[1] = 8'h02; seq[2] = 8'h00; seq[3] = 8'h40;
        do_reset();
        active = '1; sb_ready = '1; ready = 1'b1;
        has_data = 8'h20;
        @(posedge clk); #1;
        has_data = 8'h42;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (oh !== seq[c]) begin failures++; $display("FAIL wrap_oh c=%0d got=%h exp=%h", c, oh, seq[c]); end
            if (seq[c] == 8'h40) exp_q.push_back(6);
            else if (seq[c] == 8'h02) exp_q.push_back(1);
            @(posedge clk); #1;
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                checks++; if (valid !== 1'b1 || wid !== DW'(w)) begin failures++; $display("FAIL wrap_wid c=%0d got=%b/%0d exp=1/%0d", c, valid, wid, w); end
            end else begin
                checks++; if (valid !== 1'b0) begin failures++; $display("FAIL wrap_valid c=%0d got=%b exp=0", c, valid); end
            end
        end
    endtask

    task automatic test_deactivate_and_reset();
        logic [NW-1:0] seq [3];
        logic [NW-1:0] act [3];
        seq[0] = 8'h04; seq[1] = 8'h00; seq[2] = 8'h04;
        act[0] = 8'hFF; act[1] = 8'hFB; act[2] = 8'hFF;
        do_reset();
        has_data = 8'h04; sb_ready = '1; ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            active = act[c];
            #1;
            checks++; if (oh !== seq[c]) begin failures++; $display("FAIL deact_oh c=%0d got=%h exp=%h", c, oh, seq[c]); end
            @(posedge clk); #1;
        end
        checks++; if (count !== 32'd2) begin failures++; $display("FAIL deact_count got=%0d exp=2", count); end
        // Warp 2 is cooling here; an async reset must clear that and the count.
        rst_n = 1'b0;
        #1;
        checks++; if (oh !== '0) begin failures++; $display("FAIL midreset_oh got=%h exp=00", oh); end
        checks++; if (count !== 32'd0) begin failures++; $display("FAIL midreset_count got=%0d exp=0", count); end
        rst_n = 1'b1;
        #1;
        checks++; if (oh !== 8'h04) begin failures++; $display("FAIL midreset_cd_clear got=%h exp=04", oh); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [NW-1:0] e;
        int w;
        do_reset();
        has_data = '1; active = '1; sb_ready = '1; ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1;
            e = NW'(1) << (k % NW);
            checks++; if (oh !== e) begin failures++; $display("FAIL b2b_oh k=%0d got=%h exp=%h", k, oh, e); end
            exp_q.push_back(k % NW); exp_count++;
            @(posedge clk); #1;
            w = exp_q.pop_front();
            checks++; if (valid !== 1'b1 || wid !== DW'(w)) begin failures++; $display("FAIL b2b_wid k=%0d got=%b/%0d exp=1/%0d", k, valid, wid, w); end
        end
        checks++; if (count !== 32'(exp_count)) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", count, exp_count); end
        has_data = '0;
        #1;
        checks++; if (idle !== 1'b1 || oh !== '0) begin failures++; $display("FAIL b2b_idle got=%b/%h exp=1/00", idle, oh); end
    endtask

    initial begin
        #1;
        test_reset();
        test_round_robin();
        test_cooldown();
        test_backpressure();
        test_wrap_sparse();
        test_deactivate_and_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
